// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Request/response and byte-memory bundle for load_store_unit.
//            slave  = the load/store unit itself
//            master = the surrounding environment (execute stage + memory)
// Revision : 1.0  initial release
// ============================================================================
interface load_store_unit_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
);
  // execute-stage request
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_mode;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  // completion
  logic                  resp_valid;
  logic [WIDTH-1:0]      resp_rdata;
  logic                  resp_err;
  // byte-wide data memory
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wd;
  logic                  mem_we;
  logic [7:0]            mem_rd;

  modport master (
    output req_valid, req_we, req_mode, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wd, mem_we,
    output mem_rd
  );

  modport slave (
    input  req_valid, req_we, req_mode, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wd, mem_we,
    input  mem_rd
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Byte-serialising load/store unit. One byte/half/word access per
//            request, driven to a byte-wide memory one little-endian byte per
//            cycle; loads are reassembled and sign/zero extended.
// Options  : define LSU_ALIGN_CHECK_EN to reject misaligned half/word accesses
//            with resp_err instead of servicing them byte by byte.
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic                  we_q;
  logic [1:0]            mode_q;
  logic                  uns_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [WIDTH-1:0]      buf_q;

  logic                  req_bad;
  logic [1:0]            last_idx;
  logic [WIDTH-1:0]      load_val;

  // Classify the incoming request: reserved size (and, optionally, misalignment) is an error
  always_comb begin
    req_bad = (bus.req_mode == MODE_RSVD);
`ifdef LSU_ALIGN_CHECK_EN
    if ((bus.req_mode == MODE_HALF) && bus.req_addr[0])
      req_bad = 1'b1;
    if ((bus.req_mode == MODE_WORD) && (bus.req_addr[1:0] != 2'b00))
      req_bad = 1'b1;
`endif
  end

  // Index of the final beat for the latched access size (k-1)
  always_comb begin
    case (mode_q)
      MODE_BYTE: last_idx = 2'd0;
      MODE_HALF: last_idx = 2'd1;
      default:   last_idx = 2'd3;
    endcase
  end

  // Extend the captured bytes; the buffer is cleared on accept so word loads need no masking
  always_comb begin
    case (mode_q)
      MODE_BYTE: load_val = {{(WIDTH-8){buf_q[7] & ~uns_q}}, buf_q[7:0]};
      MODE_HALF: load_val = {{(WIDTH-16){buf_q[15] & ~uns_q}}, buf_q[15:0]};
      default:   load_val = buf_q;
    endcase
  end

  // State and beat-index register; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and all bus outputs; memory is only driven during ACCESS
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_rdata  = '0;
    bus.resp_err    = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wd      = 8'h00;
    bus.mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rst is folded in so ready is low for the whole reset interval
        bus.req_ready = ~rst;
        idx_d         = 2'd0;
        if (bus.req_valid)
          state_d = req_bad ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        bus.mem_addr = addr_q + ADDR_WIDTH'(idx_q);
        if (we_q) begin
          bus.mem_we = 1'b1;
          bus.mem_wd = wdata_q[{idx_q, 3'b000} +: 8];
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == last_idx)
          state_d = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        if (!we_q && !err_q)
          bus.resp_rdata = load_val;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the request on acceptance and capture load bytes beat by beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      mode_q  <= MODE_BYTE;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
    end else if ((state_q == S_IDLE) && bus.req_valid) begin
      we_q    <= bus.req_we;
      mode_q  <= bus.req_mode;
      uns_q   <= bus.req_unsigned;
      err_q   <= req_bad;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      buf_q   <= '0;
    end else if ((state_q == S_ACCESS) && !we_q) begin
      buf_q[{idx_q, 3'b000} +: 8] <= bus.mem_rd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit: directed vector table,
//            reset-abort sequence and randomized traffic against a
//            byte-array reference memory.
// Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.WIDTH(32), .ADDR_WIDTH(32)) bus ();

  load_store_unit #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 4 KiB byte memory, aliased on the low 12 address bits
  logic [7:0]  mem     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic        pl_we   = 1'b0;
  logic [11:0] pl_addr = 12'h000;
  logic [7:0]  pl_data = 8'h00;

  assign bus.mem_rd = mem[bus.mem_addr[11:0]];

  always @(posedge clk) begin
    if (pl_we)
      mem[pl_addr] <= pl_data;
    else if (bus.mem_we)
      mem[bus.mem_addr[11:0]] <= bus.mem_wd;
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [1:0]  mode;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("ready_timeout", 64'(bus.req_ready), 64'd1);
  endtask

  // Reference load: gather k bytes little-endian, then extend from bit 8k-1
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] m,
                                             input logic u);
    int          k;
    logic [63:0] v;
    logic [31:0] b;
    k = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
    v = '0;
    for (int j = 0; j < k; j++) begin
      b = a + 32'(j);
      v = v | (64'(ref_mem[b[11:0]]) << (8 * j));
    end
    if (!u && v[8*k-1]) v = v | ~((64'd1 << (8 * k)) - 64'd1);
    return v[31:0];
  endfunction

  // One full transaction, checked cycle by cycle from acceptance to ready again
  task automatic run_txn(input string nm, input logic we, input logic [1:0] mode,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err);
    int          k;
    bit          ok;
    logic [31:0] ea;
    k = exp_err ? 0 : (mode == 2'b00) ? 1 : (mode == 2'b01) ? 2 : 4;
    wait_ready(ok);
    if (!ok) return;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_mode     = mode;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    for (int c = 1; c <= k; c++) begin
      ea = addr + 32'(c - 1);
      if (we)
        chk({nm, ".beat"}, {23'd0, bus.mem_we, bus.mem_addr, bus.mem_wd},
            {23'd0, 1'b1, ea, wdata[8*(c-1) +: 8]});
      else
        chk({nm, ".beat"}, {31'd0, bus.mem_we, bus.mem_addr}, {31'd0, 1'b0, ea});
      chk({nm, ".busy"}, {62'd0, bus.req_ready, bus.resp_valid}, 64'd0);
      @(negedge clk);
    end
    chk({nm, ".resp"}, {61'd0, bus.req_ready, bus.resp_valid, bus.resp_err},
        {61'd0, 1'b0, 1'b1, exp_err});
    chk({nm, ".rdata"}, 64'(bus.resp_rdata), 64'(exp_rd));
    chk({nm, ".mem_idle"}, {23'd0, bus.mem_we, bus.mem_addr, bus.mem_wd}, 64'd0);
    @(negedge clk);
    chk({nm, ".ready_again"}, {62'd0, bus.req_ready, bus.resp_valid}, 64'd2);
    if (we && !exp_err)
      for (int j = 0; j < k; j++) begin
        ea = addr + 32'(j);
        ref_mem[ea[11:0]] = wdata[8*j +: 8];
      end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic        we, uns, err;
    logic [1:0]  mode;
    logic [31:0] addr, wdata, exp;

    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_mode     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;

    tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0,         32'hFFFF_FF80, 1'b0};
    tbl[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_0080, 1'b0};
    tbl[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0041, 32'h0,
                ALIGN ? 32'h0 : 32'hFFFF_F234, ALIGN};
    tbl[5]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0041, 32'h0,
                ALIGN ? 32'h0 : 32'h0000_F234, ALIGN};
    tbl[6]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0300, 32'h0,         32'h0, 1'b1};
    tbl[7]  = '{1'b1, 2'b11, 1'b0, 32'h0000_0304, 32'h1234_5678, 32'h0, 1'b1};
    tbl[8]  = '{1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0,
                ALIGN ? 32'h0 : 32'hC433_2211, ALIGN};
    tbl[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0050, 32'h7777_ABCD, 32'h0, 1'b0};
    tbl[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0050, 32'h0,         32'hFFFF_ABCD, 1'b0};

    // Memory contents are loaded while the unit is held in reset
    @(negedge clk);
    for (int i = 0; i < 4096; i++) preload(12'(i), 8'($urandom));
    preload(12'h020, 8'h80);
    preload(12'h041, 8'h34);
    preload(12'h042, 8'hF2);
    preload(12'hFFE, 8'h11);
    preload(12'hFFF, 8'h22);
    preload(12'h000, 8'h33);
    preload(12'h001, 8'hC4);
    preload(12'h202, 8'hA5);
    preload(12'h203, 8'h5A);

    chk("reset.ready", 64'(bus.req_ready), 64'd0);
    chk("reset.resp", {30'd0, bus.resp_valid, bus.resp_err, bus.resp_rdata}, 64'd0);
    chk("reset.mem", {23'd0, bus.mem_we, bus.mem_addr, bus.mem_wd}, 64'd0);
    rst = 1'b0;
    #1;
    chk("release.ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      run_txn($sformatf("tbl%0d", i), tbl[i].we, tbl[i].mode, tbl[i].uns, tbl[i].addr,
              tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err);

    // Reset arriving during beat 2 of a word store
    wait_ready(ok);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_mode  = 2'b10;
    bus.req_addr  = 32'h0000_0200;
    bus.req_wdata = 32'h1122_3344;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.beat2", {31'd0, bus.mem_we, bus.mem_addr}, {31'd0, 1'b1, 32'h0000_0202});
    rst = 1'b1;
    #1;
    chk("abort.we_drop", {61'd0, bus.mem_we, bus.req_ready, bus.resp_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.ready", 64'(bus.req_ready), 64'd1);
    ref_mem[12'h200] = 8'h44;
    ref_mem[12'h201] = 8'h33;
    for (int j = 0; j < 4; j++)
      chk($sformatf("abort.mem%0d", j), 64'(mem[12'h200 + 12'(j)]), 64'(ref_mem[12'h200 + 12'(j)]));
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("abort.no_resp", 64'(bus.resp_valid), 64'd0);
    end

    // Randomized traffic against the reference memory
    for (int t = 0; t < 60; t++) begin
      we   = 1'($urandom);
      uns  = 1'($urandom);
      mode = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_F000 | 32'($urandom_range(0, 4095)))
                                         : 32'($urandom_range(0, 4095));
      wdata = $urandom;
      err  = (mode == 2'b11) ||
             (ALIGN && (((mode == 2'b01) && addr[0]) || ((mode == 2'b10) && (addr[1:0] != 2'b00))));
      exp  = (we || err) ? 32'h0 : model_load(addr, mode, uns);
      run_txn($sformatf("rnd%0d", t), we, mode, uns, addr, wdata, exp, err);
    end

    // Spot-check memory against the reference after random stores
    for (int i = 0; i < 16; i++) begin
      addr = 32'($urandom_range(0, 4095));
      chk("final.mem", 64'(mem[addr[11:0]]), 64'(ref_mem[addr[11:0]]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Byte-serialising load/store unit between the execute stage and the byte-wide data memory. It accepts one word, half or byte access per request. It drives the memory one byte per cycle, little-endian. Loads are reassembled and sign- or zero-extended into a 32-bit result, and the pipeline is stalled through `req_ready` until a one-cycle response is returned.

## Interface
- `WIDTH`, 32, data width of request/response path (only 32 supported)
- `ADDR_WIDTH`, 32, byte-address width; beat addresses wrap modulo 2^ADDR_WIDTH

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle and able to accept
- `req_we`  in  1  1 = store, 0 = load
- `req_mode`  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- `req_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend
- `req_addr`  in  ADDR_WIDTH  byte address of lowest byte
- `req_wdata`  in  WIDTH  store data, low bytes used
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  WIDTH  load result (0 for stores and errors)
- `resp_err`  out  1  completion with error, valid with `resp_valid`
- `mem_addr`  out  ADDR_WIDTH  byte address to memory
- `mem_wd`  out  8  byte write data
- `mem_we`  out  1  byte write enable
- `mem_rd`  in  8  byte read data, combinational from `mem_addr`

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch we/mode/unsigned/addr/wdata, set beat count k (byte 1, half 2, word 4) and beat index i=0, then go to ACCESS.
  - Mode 11 goes directly to RESP with err=1.
- ACCESS, beat i:
  - `mem_addr`=addr+i (ADDR_WIDTH wrap).
  - Store: `mem_we`=1 and `mem_wd`=wdata[8i+7:8i].
  - Load: `mem_we`=0, and `mem_rd` is captured into buffer byte i at the clock edge.
  - i increments each cycle; after beat k-1, go to RESP.
- RESP:
  - `resp_valid`=1 for exactly one cycle.
  - Load `resp_rdata`: the k captured bytes, with upper bits filled by buffer bit 8k-1 when signed, or 0 when unsigned.
  - Store `resp_rdata`=0.
  - Then go to IDLE.
- Outside ACCESS: `mem_we`=0, `mem_addr`=0, `mem_wd`=0.
- Misaligned half/word accesses are serviced byte-by-byte unless `LSU_ALIGN_CHECK_EN` is defined.
- Requests presented while `req_ready`=0 are ignored; the upstream stage holds them.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready`=0 while `rst`=1, and 1 from the first cycle after release.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `mem_addr`=0, `mem_wd`=0, `mem_we`=0.
- Latency, with the request accepted at edge E0:
  - ACCESS occupies the k cycles after E0.
  - `resp_valid` is high in cycle k+1.
  - `req_ready` is high again in cycle k+2.
  - Totals: byte 2 cycles, half 3, word 5 from acceptance to completion.
- Error path (mode 11, or misaligned with the check enabled): `resp_valid`/`resp_err` in the cycle after acceptance, with no memory beats.
- No back-to-back acceptance: `req_ready` is low during ACCESS and RESP.
- Reset mid-operation aborts immediately:
  - `mem_we` drops asynchronously.
  - Bytes already written stay written.
  - No `resp_valid` is issued for the aborted request.
- Address wrap: word at 0xFFFFFFFE accesses FFFFFFFE, FFFFFFFF, 00000000, 00000001.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - Half with addr[0]≠0, or word with addr[1:0]≠0, generates no memory traffic.
  - Completes in the next cycle with `resp_err`=1 and `resp_rdata`=0.
- Not defined: misaligned accesses complete normally byte-serially, and `resp_err` is raised only for mode 11.

## Test plan
- Word store 0xDEADBEEF at 0x100, then word load from 0x100:
  - `mem_we` pulses for 4 cycles with `mem_wd` EF, BE, AD, DE at 0x100–0x103.
  - The load returns 0xDEADBEEF, with `resp_valid` in cycle 5 after acceptance.
- Byte load of 0x80 from 0x20:
  - Signed returns 0xFFFFFF80.
  - Unsigned returns 0x00000080.
  - `resp_valid` in cycle 2 after acceptance.
- Half load of bytes 0x34, 0xF2 from 0x41:
  - Check undefined: returns 0xFFFFF234.
  - Check defined: `resp_err`=1, `resp_rdata`=0, no `mem_addr` activity.
- Mode 11 request: `resp_valid`=1 and `resp_err`=1 in the next cycle, and `mem_we` stays 0 throughout.
- `rst` asserted during beat 2 of a word store to 0x200:
  - Only 0x200–0x201 are written.
  - No `resp_valid` is issued.
  - `req_ready`=1 in the first cycle after `rst` is released.
- Word load at 0xFFFFFFFE: beat addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001, with the bytes assembled little-endian.
